// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU memory/peripheral bus controller.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAM_ACC  = 2'd1,
        UART_ACC = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;

    localparam logic [15:0] UART_BASE_DEFAULT = 16'h0ff0;

endpackage

// File: rtl/byte_lane_steer.sv
// Combinational byte-lane steering: write-lane placement, RAM lane enables and
// read-byte extraction. An even byte address maps to the high lane [15:8].
module byte_lane_steer
    import mem_bus_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              be,
    input  logic              odd,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rword,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [1:0]        ram_be,
    output logic [DATA_W-1:0] rdata
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        ram_wdata = wdata;
        ram_be    = BE_WORD;
        rdata     = rword;
        if (be) begin
            if (odd) begin
                ram_wdata = {8'h00, wdata[7:0]};
                ram_be    = BE_LO;
                rdata     = {8'h00, rword[7:0]};
            end else begin
                ram_wdata = {wdata[7:0], 8'h00};
                ram_be    = BE_HI;
                rdata     = {8'h00, rword[15:8]};
            end
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Request/ready bus controller steering CPU accesses to word RAM or a byte UART.
// Build option MEMBUS_ALIGN_CHECK_EN: odd-address RAM word accesses end with cpu_err.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] UART_BASE = UART_BASE_DEFAULT,
    parameter int                RAM_LAT   = 1,
    parameter int                UART_WAIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_busy,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_we,
    output logic [1:0]        ram_be,
    output logic [2:0]        uart_addr,
    output logic [7:0]        uart_wdata,
    input  logic [7:0]        uart_rdata,
    output logic              uart_ce,
    output logic              uart_we,
    output logic              uart_re
);

    localparam logic [2:0] RAM_CNT  = 3'(RAM_LAT - 1);
    localparam logic [2:0] UART_CNT = 3'(UART_WAIT - 1);

    state_t            state;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic              be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] ram_rd_ext;

    byte_lane_steer #(.DATA_W(DATA_W)) u_steer (
        .be        (be_q),
        .odd       (addr_q[0]),
        .wdata     (wdata_q),
        .rword     (ram_rdata),
        .ram_wdata (ram_wdata),
        .ram_be    (ram_be),
        .rdata     (ram_rd_ext)
    );

    // All bus-side address/data come from the captured request only.
    assign ram_addr   = {1'b0, addr_q[ADDR_W-1:1]};
    assign uart_addr  = addr_q[2:0];
    assign uart_wdata = wdata_q[7:0];
    assign cpu_busy   = (state != IDLE);

`ifdef MEMBUS_ALIGN_CHECK_EN
    logic err_q;
    assign cpu_err = err_q;
`else
    assign cpu_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= 1'b0;
            wdata_q   <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            ram_we    <= 1'b0;
            uart_ce   <= 1'b0;
            uart_we   <= 1'b0;
            uart_re   <= 1'b0;
`ifdef MEMBUS_ALIGN_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            cpu_ready <= 1'b0;
            ram_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_we;
                        be_q    <= cpu_be;
                        wdata_q <= cpu_wdata;
                        if (cpu_addr >= UART_BASE) begin
                            state   <= UART_ACC;
                            cnt     <= UART_CNT;
                            uart_ce <= 1'b1;
                            uart_we <= cpu_we;
                            uart_re <= ~cpu_we;
                        end
`ifdef MEMBUS_ALIGN_CHECK_EN
                        else if (!cpu_be && cpu_addr[0]) begin
                            state     <= DONE;
                            cpu_ready <= 1'b1;
                            err_q     <= 1'b1;
                        end
`endif
                        else begin
                            state  <= RAM_ACC;
                            cnt    <= RAM_CNT;
                            ram_we <= cpu_we;
                        end
                    end
                end
                RAM_ACC: begin
                    if (cnt == 3'd0) begin
                        if (!we_q) cpu_rdata <= ram_rd_ext;
                        state     <= DONE;
                        cpu_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                UART_ACC: begin
                    if (cnt == 3'd0) begin
                        if (!we_q) cpu_rdata <= {{(DATA_W-8){1'b0}}, uart_rdata};
                        uart_ce   <= 1'b0;
                        uart_we   <= 1'b0;
                        uart_re   <= 1'b0;
                        state     <= DONE;
                        cpu_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
`ifdef MEMBUS_ALIGN_CHECK_EN
                    err_q <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomised self-checking bench for mem_bus_ctrl against a byte-addressed model.
module tb_mem_bus_ctrl;

    localparam int          RAM_LAT   = 1;
    localparam int          UART_WAIT = 2;
    localparam logic [15:0] UBASE     = 16'h0ff0;
`ifdef MEMBUS_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk, reset;
    logic        cpu_req, cpu_we, cpu_be;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ready, cpu_busy, cpu_err;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_we;
    logic [1:0]  ram_be;
    logic [2:0]  uart_addr;
    logic [7:0]  uart_wdata, uart_rdata;
    logic        uart_ce, uart_we, uart_re;

    mem_bus_ctrl #(
        .ADDR_W(16), .DATA_W(16), .UART_BASE(UBASE),
        .RAM_LAT(RAM_LAT), .UART_WAIT(UART_WAIT)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .cpu_busy(cpu_busy), .cpu_err(cpu_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .ram_we(ram_we), .ram_be(ram_be),
        .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_rdata(uart_rdata),
        .uart_ce(uart_ce), .uart_we(uart_we), .uart_re(uart_re)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-organised RAM device honouring lane enables.
    logic [15:0] ram_mem [0:65535];
    assign ram_rdata = ram_mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) begin
            if (ram_be[1]) ram_mem[ram_addr][15:8] <= ram_wdata[15:8];
            if (ram_be[0]) ram_mem[ram_addr][7:0]  <= ram_wdata[7:0];
        end
    end

    // Reference model: flat byte memory, even byte = high half of its word.
    logic [7:0]  bmem [0:65535];
    logic [15:0] exp_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_ready(output int lat, output bit seen,
                              output int c_rwe, output int c_ce, output int c_uwe,
                              output int c_ure, output int c_both,
                              input bit is_uart, input bit mis, input logic we,
                              input logic be, input logic [15:0] addr, input logic [15:0] wd);
        logic [1:0]  exp_be;
        logic [15:0] exp_wd;
        exp_be = !be ? 2'b11 : (addr[0] ? 2'b01 : 2'b10);
        exp_wd = !be ? wd : (addr[0] ? {8'h00, wd[7:0]} : {wd[7:0], 8'h00});
        lat = 0; seen = 0;
        c_rwe = 0; c_ce = 0; c_uwe = 0; c_ure = 0; c_both = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            c_rwe  += int'(ram_we);
            c_ce   += int'(uart_ce);
            c_uwe  += int'(uart_we);
            c_ure  += int'(uart_re);
            c_both += int'(uart_we & uart_re);
            if (lat == 1) begin
                check("busy_in_txn", cpu_busy, 1'b1);
                if (is_uart) begin
                    check("uart_addr", uart_addr, addr[2:0]);
                    if (we) check("uart_wdata", uart_wdata, wd[7:0]);
                end else if (!mis) begin
                    check("ram_addr", ram_addr, {1'b0, addr[15:1]});
                    check("ram_be", ram_be, exp_be);
                    if (we) check("ram_wdata", ram_wdata, exp_wd);
                end
            end
            if (cpu_ready) seen = 1;
        end
    endtask

    task automatic txn(input logic we, input logic be, input logic [15:0] addr,
                       input logic [15:0] wd, input logic [7:0] urd, input bit hold);
        bit is_uart, mis, seen;
        int lat, exp_lat, c_rwe, c_ce, c_uwe, c_ure, c_both;
        logic [15:0] wa;
        is_uart = (addr >= UBASE);
        mis     = ALIGN && !is_uart && !be && addr[0];
        exp_lat = mis ? 1 : (is_uart ? UART_WAIT + 1 : RAM_LAT + 1);
        wa      = {addr[15:1], 1'b0};

        cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wd;
        uart_rdata = urd;
        @(posedge clk); #1;
        if (!hold) begin
            cpu_req = 1'b0;
            cpu_we = 1'($urandom); cpu_be = 1'($urandom);
            cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
        end
        wait_ready(lat, seen, c_rwe, c_ce, c_uwe, c_ure, c_both, is_uart, mis, we, be, addr, wd);

        // Model update follows the byte-addressed view of memory.
        if (!is_uart && !mis && we) begin
            if (be) bmem[addr] = wd[7:0];
            else begin
                bmem[wa]         = wd[15:8];
                bmem[wa | 16'h1] = wd[7:0];
            end
        end
        if (!mis && !we) begin
            if (is_uart)  exp_rdata = {8'h00, urd};
            else if (be)  exp_rdata = {8'h00, bmem[addr]};
            else          exp_rdata = {bmem[wa], bmem[wa | 16'h1]};
        end

        check("ready_seen", seen, 1'b1);
        check("latency", lat, exp_lat);
        check("ram_we_cycles", c_rwe, (!is_uart && !mis && we) ? 1 : 0);
        check("uart_ce_cycles", c_ce, is_uart ? UART_WAIT : 0);
        check("uart_we_cycles", c_uwe, (is_uart && we) ? UART_WAIT : 0);
        check("uart_re_cycles", c_ure, (is_uart && !we) ? UART_WAIT : 0);
        check("uart_we_re_both", c_both, 0);
        check("cpu_rdata", cpu_rdata, exp_rdata);
        check("cpu_err", cpu_err, mis);

        @(negedge clk);
        check("idle_after_done", cpu_busy, 1'b0);
        check("ready_one_cycle", cpu_ready, 1'b0);
        if (hold) begin
            // req stayed high: the IDLE edge must accept it again.
            @(negedge clk);
            check("hold_reaccept", cpu_busy, 1'b1);
            cpu_req = 1'b0;
            lat = 1;
            seen = cpu_ready;
            while (!seen && lat < 20) begin
                @(negedge clk);
                lat++;
                if (cpu_ready) seen = 1;
            end
            check("hold_ready_seen", seen, 1'b1);
            check("hold_latency", lat, exp_lat);
            check("hold_rdata", cpu_rdata, exp_rdata);
            @(negedge clk);
        end
    endtask

    task automatic reset_mid_uart();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 1'b1; cpu_addr = UBASE; cpu_wdata = 16'h0033;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
        check("rst_uart_ce_c1", uart_ce, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_uart_ce", uart_ce, 1'b0);
        check("rst_uart_we", uart_we, 1'b0);
        check("rst_uart_re", uart_re, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_busy", cpu_busy, 1'b0);
        check("rst_ready", cpu_ready, 1'b0);
        reset = 1'b0;
        exp_rdata = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_ready", cpu_ready, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) begin
            ram_mem[i] = 16'h0000;
            bmem[i]    = 8'h00;
        end
        exp_rdata = 16'h0000;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 1'b0;
        cpu_addr = 16'h0000; cpu_wdata = 16'h0000; uart_rdata = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_rdata", cpu_rdata, 16'h0000);
        check("reset_ready", cpu_ready, 1'b0);
        check("reset_busy", cpu_busy, 1'b0);
        check("reset_err", cpu_err, 1'b0);
        check("reset_ram_be", ram_be, 2'b11);
        check("reset_strobes", {ram_we, uart_ce, uart_we, uart_re}, 4'b0000);

        // Directed cases.
        txn(1'b1, 1'b0, 16'h0100, 16'hBEEF, 8'h00, 1'b0);
        txn(1'b0, 1'b0, 16'h0100, 16'h0000, 8'h00, 1'b0);
        check("word_read_beef", cpu_rdata, 16'hBEEF);
        txn(1'b1, 1'b1, 16'h0101, 16'h775A, 8'h00, 1'b0);
        txn(1'b1, 1'b1, 16'h0100, 16'h11A5, 8'h00, 1'b0);
        txn(1'b0, 1'b1, 16'h0101, 16'h0000, 8'h00, 1'b0);
        check("byte_read_odd", cpu_rdata, 16'h005A);
        txn(1'b0, 1'b1, 16'h0100, 16'h0000, 8'h00, 1'b0);
        check("byte_read_even", cpu_rdata, 16'h00A5);
        txn(1'b1, 1'b1, 16'h0ff0, 16'h0041, 8'h00, 1'b0);
        check("write_keeps_rdata", cpu_rdata, 16'h00A5);
        txn(1'b0, 1'b1, 16'h0ff5, 16'h0000, 8'h60, 1'b0);
        check("uart_read", cpu_rdata, 16'h0060);
        txn(1'b1, 1'b1, 16'h0fef, 16'h00C3, 8'h00, 1'b0);
        txn(1'b0, 1'b1, 16'h0ff0, 16'h0000, 8'h9D, 1'b0);
        txn(1'b1, 1'b0, 16'h0102, 16'h1234, 8'h00, 1'b0);
        txn(1'b0, 1'b0, 16'h0103, 16'h0000, 8'h00, 1'b0);
        txn(1'b0, 1'b0, 16'h0100, 16'h0000, 8'h00, 1'b1);
        reset_mid_uart();
        txn(1'b0, 1'b0, 16'h0100, 16'h0000, 8'h00, 1'b0);

        // Randomised traffic, biased toward the decode boundary and a small hot region.
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 16'($urandom_range(0, 16'h0fef));
                1:       a = 16'($urandom_range(16'h0fe8, 16'h0ff7));
                2:       a = 16'($urandom_range(16'h0ff0, 16'hffff));
                default: a = 16'($urandom_range(16'h0100, 16'h010f));
            endcase
            txn(1'($urandom), 1'($urandom), a, 16'($urandom), 8'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Clocked, parametrised CPU-to-memory/peripheral bus controller.
- Replaces the purely combinational RAM/UART glue with a request/ready handshake and configurable RAM and UART wait states.
- Steers byte lanes for byte and word accesses and registers the read data.
- Sits between the CPU core and the word-organised RAM plus the 16450-style UART.

Parameters:
- ADDR_W, 16, CPU byte-address width.
- DATA_W, 16, word width; fixed at 16 because byte steering assumes two lanes.
- UART_BASE, 16'h0ff0, first byte address decoded to UART; addresses >= UART_BASE go to UART, all others to RAM.
- RAM_LAT, 1, cycles spent in RAM access state (1..7).
- UART_WAIT, 2, cycles the UART strobes are held (1..7).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  access request, sampled only in IDLE.
- cpu_we  in  1  1 = write.
- cpu_be  in  1  1 = byte access, 0 = word access.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  DATA_W  write data; byte in [7:0].
- cpu_rdata  out  DATA_W  registered read data; byte reads zero-extended.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high whenever state != IDLE.
- cpu_err  out  1  alignment error, valid with cpu_ready.
- ram_addr  out  ADDR_W  word address = {1'b0, addr[ADDR_W-1:1]}.
- ram_wdata  out  DATA_W  lane-steered write data.
- ram_rdata  in  DATA_W  RAM read word.
- ram_we  out  1  RAM write strobe.
- ram_be  out  2  lane enables: 11 word, 01 low byte, 10 high byte.
- uart_addr  out  3  equals addr[2:0].
- uart_wdata  out  8  equals wdata[7:0].
- uart_rdata  in  8  UART read byte.
- uart_ce, uart_we, uart_re  out  1 each  UART strobes.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - cpu_rdata = 0, cpu_ready = 0, cpu_busy = 0, cpu_err = 0.
  - All RAM/UART strobes = 0, ram_be = 11.
- States: IDLE, RAM_ACC, UART_ACC, DONE.
- IDLE: on cpu_req = 1, latch addr, we, be and wdata at the clock edge, then decode:
  - addr >= UART_BASE: go to UART_ACC.
  - otherwise: go to RAM_ACC.
- Address, data and lane outputs are driven only from the latched values, so CPU inputs may change after acceptance.
- RAM_ACC:
  - Lasts RAM_LAT cycles.
  - ram_we is high in the first cycle only, and only for writes.
  - ram_be and ram_wdata are held for the whole state.
  - On the last cycle, cpu_rdata captures:
    - word access: ram_rdata.
    - byte access, odd address: {8'h00, ram_rdata[7:0]}.
    - byte access, even address: {8'h00, ram_rdata[15:8]}.
  - Then go to DONE.
- Byte write steering:
  - Odd address: ram_wdata = {8'h00, b}, ram_be = 01.
  - Even address: ram_wdata = {b, 8'h00}, ram_be = 10.
  - b = wdata[7:0].
- UART_ACC:
  - uart_ce is high for UART_WAIT cycles.
  - uart_we is high for the same cycles on a write; uart_re on a read. Never both.
  - On the last cycle, cpu_rdata = {8'h00, uart_rdata} (reads only), then go to DONE.
  - cpu_be is ignored; UART accesses are always byte accesses.
- DONE:
  - cpu_ready = 1 for exactly this cycle.
  - Always return to IDLE next cycle; no request is accepted in DONE.
- Latency from request edge to the cpu_ready cycle: RAM = RAM_LAT + 1, UART = UART_WAIT + 1.
- cpu_rdata keeps its value until the next read completes. Writes leave cpu_rdata unchanged.
- Boundary cases:
  - cpu_req still high in IDLE after DONE is accepted as a new transaction; the CPU drops req on cpu_ready.
  - addr = UART_BASE - 1 goes to RAM; addr = UART_BASE goes to UART.
  - Reset during any state: state goes to IDLE at that edge, strobes drop, no cpu_ready is issued.

Optional Feature:
- Macro: MEMBUS_ALIGN_CHECK_EN.
- Defined:
  - A word access (cpu_be = 0) to an odd RAM address goes IDLE -> DONE directly.
  - No RAM strobes are issued and cpu_rdata is left unchanged.
  - cpu_err = 1 together with cpu_ready.
- Undefined:
  - addr[0] is ignored for word accesses.
  - cpu_err is tied to 0.

Decomposition:
- Package mem_bus_pkg holds:
  - the state enum.
  - byte-enable constants BE_WORD = 2'b11, BE_LO = 2'b01, BE_HI = 2'b10.
  - default UART_BASE.
- Sub-module byte_lane_steer (combinational) holds write lane steering, ram_be generation and read byte extraction/zero-extension.
- The FSM and counters stay in the top module.

Test Plan:
- Word write 16'hBEEF to 0x0100, then word read of 0x0100 (RAM_LAT = 1) -> ram_addr = 0x0080, ram_be = 11, ram_we for one cycle; cpu_ready two cycles after each request; read returns 16'hBEEF.
- Byte write 8'h5A to 0x0101 -> ram_wdata = 16'h005A, ram_be = 01. Byte write 8'hA5 to 0x0100 -> ram_wdata = 16'hA500, ram_be = 10. Byte reads of 0x0101 / 0x0100 -> 16'h005A / 16'h00A5.
- Byte write 8'h41 to 0x0ff0 (UART_WAIT = 2) -> uart_ce and uart_we high for 2 cycles, uart_addr = 0, uart_wdata = 8'h41; read of 0x0ff5 with uart_rdata = 8'h60 -> uart_re for 2 cycles, cpu_rdata = 16'h0060.
- Decode edges: 0x0fef -> RAM strobes only; 0x0ff0 -> UART strobes only.
- Assert reset in the second UART_ACC cycle -> all strobes 0 and state IDLE at that edge; no cpu_ready; the next request completes normally.
- With MEMBUS_ALIGN_CHECK_EN: word read of 0x0103 -> no ram_we/ram_be activity, cpu_ready = 1 with cpu_err = 1 one cycle after the request; without the macro -> normal read of word 0x0081, cpu_err = 0.
